mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified MainMemoryModule between the CPU's instruction-fetch port and its data port.
- Lets the single-cycle core be reworked toward a von Neumann memory with stall support.
- Arbitrates with data-first fixed priority, bounded by an instruction-fetch starvation counter.
- Tracks the one outstanding read and returns read data to the requester that owns it.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from address issue to valid mem_rdata (legal 1..7).
- STARVE_MAX, 4, consecutive lost IF arbitration cycles before IF is forced to win.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DW  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DW  load data.
- mem_addr  out  AW  to memory address.
- mem_re  out  1  to memory readEnable.
- mem_we  out  1  to memory writeEnable.
- mem_wdata  out  DW  to memory dataIn.
- mem_rdata  in  DW  from memory dataOut.
- busy  out  1  read outstanding.

Behaviour:
- States: IDLE (may grant) and WAIT (read outstanding, lat_cnt counting).
- Reset (rst=0, asynchronous):
  - state=IDLE, lat_cnt=0, starve_cnt=0, owner=IF.
  - All gnt/rvalid/mem_re/mem_we/busy=0; mem_addr, mem_wdata, if_rdata, d_rdata=0.
- Arbitration is combinational in IDLE, or in the WAIT cycle where lat_cnt reaches MEM_LAT (rvalid cycle):
  - Winner is IF if if_req && (!d_req || starve_cnt==STARVE_MAX); otherwise D if d_req.
  - At most one gnt per cycle; gnt is asserted only when the matching req is high.
- In the grant cycle, mem_addr, mem_re/mem_we and mem_wdata are driven combinationally from the winner.
  - mem_wdata=0 unless it is a D write.
  - In a non-grant cycle all mem_* = 0.
- Write grant: the memory write happens at that posedge. There is no response phase and the state stays IDLE, so back-to-back writes run every cycle.
- Read grant:
  - owner is latched, state goes to WAIT, lat_cnt=1.
  - lat_cnt increments each cycle while in WAIT.
  - When lat_cnt==MEM_LAT, the owner's rvalid=1 for exactly one cycle and owner rdata=mem_rdata. The other rdata output is 0.
  - In that same cycle a new grant is allowed. If one is made, the state stays or re-enters WAIT with lat_cnt=1; otherwise the state returns to IDLE.
  - Net effect with MEM_LAT=1: one read per cycle, each with 1-cycle latency.
- busy=1 whenever state=WAIT.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each grant-eligible cycle where if_req=1 and IF is not granted.
  - Cleared to 0 on an IF grant.
  - Unchanged on non-eligible cycles.
- Requester protocol: req and its address/data are held stable until gnt. Dropping req before gnt is legal and withdraws the request with no side effect.
- Simultaneous if_req and d_req with starve_cnt<STARVE_MAX: D wins, starve_cnt+1.
- Reset mid-read: the outstanding read is abandoned, no rvalid is ever produced for it, and the state is IDLE on release.
- Addresses pass unmodified; there is no width conversion.

Decomposition:
- Shared package holds:
  - the state encoding localparams (ST_IDLE, ST_WAIT);
  - the owner encoding (OWN_IF=0, OWN_D=1);
  - the default AW/DW.
- One natural sub-module: arb_prio_starve, a combinational priority pick plus the saturating starvation counter. Everything else stays in mem_arbiter.

Test Plan:
- Reset check: rst=0 mid-read (1 cycle after if_gnt) → all outputs 0, no if_rvalid after release, busy=0.
- IF-only reads, MEM_LAT=1: if_req held with addrs 0x0,0x4,0x8 → if_gnt every cycle, if_rvalid 1 cycle after each grant, if_rdata equals the memory contents at those addrs.
- Data write then read: d_we=1 d_addr=0x100 d_wdata=0xDEADBEEF, then a read of 0x100 → mem_we pulses 1 cycle; d_rvalid the cycle after the read grant with d_rdata=0xDEADBEEF; if_rvalid stays 0.
- Contention and starvation, STARVE_MAX=4: if_req and d_req held high with D doing reads → 4 consecutive d_gnt, then 1 if_gnt, then starve_cnt=0 and the pattern repeats.
- MEM_LAT=3: IF read granted at cycle T with d_req pending → no grant at T+1 and T+2 (busy=1); if_rvalid and d_gnt both at T+3.
- Withdrawal: if_req pulsed 1 cycle while D owns a 3-cycle read and then dropped → no if_gnt, no memory access at that address, starve_cnt unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Latency counter width: covers MEM_LAT up to 7
    localparam int LAT_W = 3;

    // FSM state encoding
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Owner of the outstanding read
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Data-first fixed-priority pick with an instruction-fetch starvation
// counter that forces IF to win after STARVE_MAX consecutive losses.
module arb_prio_starve
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_elig,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_win,
    output logic o_d_win
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == SMAX);

    // Winner select: D has priority unless IF has been starved long enough
    always_comb begin
        o_if_win = i_elig && i_if_req && (!i_d_req || w_starved);
        o_d_win  = i_elig && i_d_req && !o_if_win;
    end

    // Count eligible cycles IF asked and lost; clear on an IF grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (o_if_win) begin
            r_starve <= '0;
        end else if (i_elig && i_if_req && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the IF and data ports. Writes complete in the
// grant cycle; one read may be outstanding and its data is steered back to
// the requester that owns it. A new grant is allowed in the rvalid cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT);

    logic             r_state;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             r_owner;

    logic             w_next_state;
    logic [LAT_W-1:0] w_next_lat;
    logic             w_next_owner;

    logic w_rv_cycle;
    logic w_elig;
    logic w_if_win;
    logic w_d_win;
    logic w_rd_grant;

    // Read data returns on the last WAIT cycle, which also reopens arbitration
    assign w_rv_cycle = (r_state == ST_WAIT) && (r_lat_cnt == LAT_MAX);
    // Gate with reset so nothing is granted while reset is held
    assign w_elig     = rst && ((r_state == ST_IDLE) || w_rv_cycle);
    assign w_rd_grant = w_if_win || (w_d_win && !d_we);

    arb_prio_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .i_elig  (w_elig),
        .i_if_req(if_req),
        .i_d_req (d_req),
        .o_if_win(w_if_win),
        .o_d_win (w_d_win)
    );

    // State register: an in-flight read is simply dropped on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
            r_owner   <= OWN_IF;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_next_lat;
            r_owner   <= w_next_owner;
        end
    end

    // Next state: a read grant (re)starts WAIT, the rvalid cycle ends it
    always_comb begin
        w_next_state = r_state;
        w_next_lat   = r_lat_cnt;
        w_next_owner = r_owner;
        if (w_rd_grant) begin
            w_next_state = ST_WAIT;
            w_next_lat   = LAT_W'(1);
            w_next_owner = w_if_win ? OWN_IF : OWN_D;
        end else if (w_rv_cycle) begin
            w_next_state = ST_IDLE;
            w_next_lat   = '0;
        end else if (r_state == ST_WAIT) begin
            w_next_lat   = r_lat_cnt + LAT_W'(1);
        end
    end

    // Outputs: memory bus follows the winner, read data goes to its owner
    always_comb begin
        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_re    = w_rd_grant;
        mem_we    = w_d_win && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_win) begin
            mem_addr = if_addr;
        end else if (w_d_win) begin
            mem_addr = d_addr;
            if (d_we) mem_wdata = d_wdata;
        end
        if_rvalid = w_rv_cycle && (r_owner == OWN_IF);
        d_rvalid  = w_rv_cycle && (r_owner == OWN_D);
        if_rdata  = (w_rv_cycle && (r_owner == OWN_IF)) ? mem_rdata : '0;
        d_rdata   = (w_rv_cycle && (r_owner == OWN_D))  ? mem_rdata : '0;
        busy      = (r_state == ST_WAIT);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// a latency-matched memory model. Read data is scoreboarded through queues
// popped by a monitor thread whenever an rvalid appears.
module tb_mem_arbiter;

    localparam int N = 2;

    logic clk;
    logic rst;

    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic [31:0] mem_addr  [N];
    logic        mem_re    [N];
    logic        mem_we    [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        busy      [N];

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] qi0 [$];
    logic [31:0] qd0 [$];
    logic [31:0] qi1 [$];
    logic [31:0] qd1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] wmem [logic [31:0]];
        logic [31:0] pipe [8];

        // Unwritten locations read back as 0xA0000000 | address
        function automatic logic [31:0] rd(input logic [31:0] a);
            if (wmem.exists(a)) return wmem[a];
            return 32'hA000_0000 | a;
        endfunction

        always @(posedge clk) begin
            pipe[0] <= mem_re[g] ? rd(mem_addr[g]) : 32'h0;
            for (int s = 1; s < 8; s++) pipe[s] <= pipe[s-1];
            if (mem_we[g]) wmem[mem_addr[g]] = mem_wdata[g];
        end

        assign mem_rdata[g] = pipe[LAT-1];

        mem_arbiter #(
            .AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]),
            .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_re(mem_re[g]), .mem_we(mem_we[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < N; g++) begin
            if_req[g] = 1'b0; if_addr[g] = 32'h0;
            d_req[g]  = 1'b0; d_we[g]    = 1'b0;
            d_addr[g] = 32'h0; d_wdata[g] = 32'h0;
        end
    endtask

    task automatic chk_quiet(input int g, input string tag);
        chk1({tag, "_if_gnt"},    if_gnt[g],    1'b0);
        chk1({tag, "_d_gnt"},     d_gnt[g],     1'b0);
        chk1({tag, "_mem_re"},    mem_re[g],    1'b0);
        chk1({tag, "_mem_we"},    mem_we[g],    1'b0);
        chk ({tag, "_mem_addr"},  mem_addr[g],  32'h0);
        chk ({tag, "_mem_wdata"}, mem_wdata[g], 32'h0);
        chk1({tag, "_if_rvalid"}, if_rvalid[g], 1'b0);
        chk1({tag, "_d_rvalid"},  d_rvalid[g],  1'b0);
        chk ({tag, "_if_rdata"},  if_rdata[g],  32'h0);
        chk ({tag, "_d_rdata"},   d_rdata[g],   32'h0);
        chk1({tag, "_busy"},      busy[g],      1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        e_if, e_d, e_ifv, e_dv, e_busy, e_re;
        logic [31:0] e_addr;

        rst = 1'b0;
        idle_all();

        // Monitor: pop and compare on every rvalid
        fork
            forever begin
                @(negedge clk);
                if (if_rvalid[0]) begin
                    if (qi0.size() == 0) chk1("if0_unexpected_rvalid", if_rvalid[0], 1'b0);
                    else chk("if0_rdata", if_rdata[0], qi0.pop_front());
                    chk("d0_rdata_idle", d_rdata[0], 32'h0);
                end
                if (d_rvalid[0]) begin
                    if (qd0.size() == 0) chk1("d0_unexpected_rvalid", d_rvalid[0], 1'b0);
                    else chk("d0_rdata", d_rdata[0], qd0.pop_front());
                    chk("if0_rdata_idle", if_rdata[0], 32'h0);
                end
                if (if_rvalid[1]) begin
                    if (qi1.size() == 0) chk1("if1_unexpected_rvalid", if_rvalid[1], 1'b0);
                    else chk("if1_rdata", if_rdata[1], qi1.pop_front());
                    chk("d1_rdata_idle", d_rdata[1], 32'h0);
                end
                if (d_rvalid[1]) begin
                    if (qd1.size() == 0) chk1("d1_unexpected_rvalid", d_rvalid[1], 1'b0);
                    else chk("d1_rdata", d_rdata[1], qd1.pop_front());
                    chk("if1_rdata_idle", if_rdata[1], 32'h0);
                end
            end
        join_none

        // Reset held with both requests raised: everything must stay quiet
        for (int g = 0; g < N; g++) begin
            if_req[g] = 1'b1; if_addr[g] = 32'h44;
            d_req[g]  = 1'b1; d_we[g] = 1'b1;
            d_addr[g] = 32'h88; d_wdata[g] = 32'h5555_AAAA;
        end
        @(negedge clk);
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");
        tick();
        idle_all();
        rst = 1'b1;
        tick();

        // IF-only reads, MEM_LAT=1
        for (int i = 0; i < 4; i++) begin
            if_req[0]  = (i < 3);
            if_addr[0] = 32'(i * 4);
            if (i < 3) qi0.push_back(32'hA000_0000 | 32'(i * 4));
            @(negedge clk);
            chk1($sformatf("ifrd_gnt i%0d", i), if_gnt[0], (i < 3));
            if (i < 3) chk($sformatf("ifrd_addr i%0d", i), mem_addr[0], 32'(i * 4));
            chk1($sformatf("ifrd_rvalid i%0d", i), if_rvalid[0], (i > 0));
            tick();
        end

        // Back-to-back writes then reads of the same locations, MEM_LAT=1
        for (int k = 0; k < 6; k++) begin
            d_req[0]   = (k < 4);
            d_we[0]    = (k < 2);
            d_addr[0]  = (k == 0 || k == 2) ? 32'h100 : 32'h104;
            d_wdata[0] = (k == 0) ? 32'hDEAD_BEEF : (k == 1) ? 32'hCAFE_F00D : 32'h1234_5678;
            if (k == 2) qd0.push_back(32'hDEAD_BEEF);
            if (k == 3) qd0.push_back(32'hCAFE_F00D);
            @(negedge clk);
            chk1($sformatf("wr_d_gnt k%0d", k), d_gnt[0], (k < 4));
            chk1($sformatf("wr_mem_we k%0d", k), mem_we[0], (k < 2));
            chk1($sformatf("wr_mem_re k%0d", k), mem_re[0], (k == 2 || k == 3));
            chk($sformatf("wr_mem_wdata k%0d", k), mem_wdata[0],
                (k == 0) ? 32'hDEAD_BEEF : (k == 1) ? 32'hCAFE_F00D : 32'h0);
            chk1($sformatf("wr_d_rvalid k%0d", k), d_rvalid[0], (k == 3 || k == 4));
            chk1($sformatf("wr_if_rvalid k%0d", k), if_rvalid[0], 1'b0);
            chk1($sformatf("wr_busy k%0d", k), busy[0], (k == 3 || k == 4));
            tick();
        end
        idle_all();

        // Contention, MEM_LAT=1: four D grants then one forced IF grant, twice
        for (int k = 0; k < 11; k++) begin
            if_req[0] = (k < 10); if_addr[0] = 32'h20;
            d_req[0]  = (k < 10); d_addr[0]  = 32'h40; d_we[0] = 1'b0;
            e_if = (k < 10) && (k % 5 == 4);
            e_d  = (k < 10) && !e_if;
            if (e_if) qi0.push_back(32'hA000_0020);
            if (e_d)  qd0.push_back(32'hA000_0040);
            @(negedge clk);
            chk1($sformatf("starve_if_gnt k%0d", k), if_gnt[0], e_if);
            chk1($sformatf("starve_d_gnt k%0d", k), d_gnt[0], e_d);
            tick();
        end
        idle_all();

        // MEM_LAT=3: IF read blocks D for two cycles, then a D read, during
        // which a 1-cycle IF request is withdrawn
        for (int k = 0; k < 8; k++) begin
            if_req[1] = (k == 0 || k == 4);
            if_addr[1] = (k == 0) ? 32'h10 : (k == 4) ? 32'h30 : 32'h0;
            d_req[1]  = (k >= 1 && k <= 3);
            d_addr[1] = 32'h50; d_we[1] = 1'b0;
            if (k == 0) qi1.push_back(32'hA000_0010);
            if (k == 3) qd1.push_back(32'hA000_0050);
            e_if   = (k == 0);
            e_d    = (k == 3);
            e_ifv  = (k == 3);
            e_dv   = (k == 6);
            e_busy = (k >= 1 && k <= 6);
            e_re   = (k == 0 || k == 3);
            e_addr = (k == 0) ? 32'h10 : (k == 3) ? 32'h50 : 32'h0;
            @(negedge clk);
            chk1($sformatf("lat3_if_gnt k%0d", k), if_gnt[1], e_if);
            chk1($sformatf("lat3_d_gnt k%0d", k), d_gnt[1], e_d);
            chk1($sformatf("lat3_if_rvalid k%0d", k), if_rvalid[1], e_ifv);
            chk1($sformatf("lat3_d_rvalid k%0d", k), d_rvalid[1], e_dv);
            chk1($sformatf("lat3_busy k%0d", k), busy[1], e_busy);
            chk1($sformatf("lat3_mem_re k%0d", k), mem_re[1], e_re);
            chk($sformatf("lat3_mem_addr k%0d", k), mem_addr[1], e_addr);
            tick();
        end
        idle_all();

        // Contention, MEM_LAT=3: grants only every third cycle; IF wins on
        // the fifth eligible cycle, so the withdrawal left starve_cnt at 0
        for (int k = 0; k < 16; k++) begin
            if_req[1] = (k <= 12); if_addr[1] = 32'h34;
            d_req[1]  = (k <= 12); d_addr[1]  = 32'h44; d_we[1] = 1'b0;
            e_if = (k == 12);
            e_d  = (k < 12) && (k % 3 == 0);
            if (e_if) qi1.push_back(32'hA000_0034);
            if (e_d)  qd1.push_back(32'hA000_0044);
            @(negedge clk);
            chk1($sformatf("lat3c_if_gnt k%0d", k), if_gnt[1], e_if);
            chk1($sformatf("lat3c_d_gnt k%0d", k), d_gnt[1], e_d);
            chk1($sformatf("lat3c_busy k%0d", k), busy[1], (k >= 1));
            tick();
        end
        idle_all();
        @(negedge clk);
        chk1("lat3c_busy_end", busy[1], 1'b0);
        tick();

        // Reset one cycle after an IF grant: the read must vanish
        if_req[1] = 1'b1; if_addr[1] = 32'h8;
        @(negedge clk);
        chk1("rstmid_if_gnt", if_gnt[1], 1'b1);
        tick();
        if_req[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet(1, "rstmid");
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1($sformatf("rstmid_no_rvalid k%0d", k), if_rvalid[1], 1'b0);
            chk1($sformatf("rstmid_busy k%0d", k), busy[1], 1'b0);
            tick();
        end

        chk("q_if0_empty", 32'(qi0.size()), 32'h0);
        chk("q_d0_empty",  32'(qd0.size()), 32'h0);
        chk("q_if1_empty", 32'(qi1.size()), 32'h0);
        chk("q_d1_empty",  32'(qd1.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
